// File: rtl/spi_pll_cfg_ctrl.sv
// PLL configuration-port sequencer: bus accesses and reset/relock.
// Optional PLL_CFG_TIMEOUT_EN adds a PLLACK wait timeout in BUS.
module spi_pll_cfg_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int RST_CYC     = 8,
  parameter int LOCK_CYC    = 4095
) (
  input  logic       PLLCLK,
  input  logic       RST_N,
  input  logic       CFG_REQ,
  input  logic       CFG_WE,
  input  logic [4:0] CFG_ADDR,
  input  logic [7:0] CFG_WDATA,
  input  logic       CFG_APPLY,
  output logic       CFG_BUSY,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic [7:0] CFG_RDATA,
  output logic       PLLSTB,
  output logic       PLLWE,
  output logic [4:0] PLLADDR,
  output logic [7:0] PLLDATI,
  input  logic [7:0] PLLDATO,
  input  logic       PLLACK,
  output logic       PLLRST,
  input  logic       LOCK
);

  localparam int M1 =
    (RST_CYC > LOCK_CYC) ? RST_CYC : LOCK_CYC;
  localparam int MAXC =
    (TIMEOUT_CYC > M1) ? TIMEOUT_CYC : M1;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);
`ifdef PLL_CFG_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, BUS, RSTP, LOCKW, FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    dati_q, dati_d;
  logic          rst_q, rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          lock_s1_q, lock_s2_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q
                                 : cnt_q + CW'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dati_d  = dati_q;
    rst_d   = rst_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (CFG_REQ) begin
          state_d = BUS;
          stb_d   = 1'b1;
          we_d    = CFG_WE;
          addr_d  = CFG_ADDR;
          dati_d  = CFG_WDATA;
        end else if (CFG_APPLY) begin
          state_d = RSTP;
          rst_d   = 1'b1;
        end
      end
      BUS: begin
        if (PLLACK) begin
          state_d = FIN;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = PLLDATO;
        end
`ifdef PLL_CFG_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = FIN;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      RSTP: begin
        if (cnt_q == RST_LAST) begin
          state_d = LOCKW;
          rst_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCKW: begin
        if (lock_s2_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter, output and LOCK synchroniser registers
  always_ff @(posedge PLLCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dati_q    <= '0;
      rst_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dati_q    <= dati_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      lock_s1_q <= LOCK;
      lock_s2_q <= lock_s1_q;
    end
  end

  assign CFG_BUSY  = busy_q;
  assign CFG_DONE  = done_q;
  assign CFG_ERR   = err_q;
  assign CFG_RDATA = rdata_q;
  assign PLLSTB    = stb_q;
  assign PLLWE     = we_q;
  assign PLLADDR   = addr_q;
  assign PLLDATI   = dati_q;
  assign PLLRST    = rst_q;

endmodule
